rng_word_packer: RTL and testbench

Collects the one-cycle byte pulses produced by the LFSR whitening/sampling stage and packs them into fixed-width random words. Completed words are buffered in a small FIFO and handed to the consumer (the simulator's random-number consumers) over a valid/ready handshake. The sampling stage has no backpressure, so this block absorbs bursts and reports any words it loses.

---
 rtl/rng_pkg.sv | 19 +
 rtl/rng_sync_fifo.sv | 75 +++++++
 rtl/rng_word_packer.sv | 92 +++++++++
 tb/tb_rng_word_packer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared constants and helpers for the random-word packer and its FIFO.
// Holds the byte width, default geometry and the width-sizing function.
package rng_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEF_WORD_BYTES = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // Smallest r with (1 << r) >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// Show-ahead synchronous FIFO with a word-count output and synchronous flush.
// A push into a full FIFO is only written when a pop happens in the same cycle.
module rng_sync_fifo
  import rng_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             wr_en;
  logic             rd_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;

  assign rd_en = pop && !empty && !clear;
  assign wr_en = push && (!full || rd_en) && !clear;

  // Masked read keeps the head at zero whenever nothing is stored.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the head mask hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rng_word_packer.sv
// Packs one-cycle byte pulses little-endian into words, buffers them and
// hands them out over valid/ready, flagging any completed word that is lost.
module rng_word_packer
  import rng_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         byte_valid,
  input  logic [BYTE_W-1:0]            byte_data,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [BYTE_W*WORD_BYTES-1:0] word_data,
  output logic [clog2(FIFO_DEPTH):0]   fill_level,
  output logic                         overflow
);

  // Handshake: a word transfers on any rising edge where word_valid and
  // word_ready are both high; word_data is stable while word_valid waits.

  localparam int IW = clog2(WORD_BYTES);
  localparam int WW = BYTE_W * WORD_BYTES;

  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] shift_q, shift_d;
  logic          overflow_q, overflow_d;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign word_valid = !fifo_empty;
  assign pop        = word_valid && word_ready;
  assign overflow   = overflow_q;

  // The pushed word includes the byte arriving this cycle, so it comes from shift_d.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    push    = 1'b0;
    if (byte_valid) begin
      shift_d[BYTE_W*int'(idx_q) +: BYTE_W] = byte_data;
      if (idx_q == IW'(WORD_BYTES - 1)) begin
        idx_d = '0;
        push  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      idx_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

  rng_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (shift_d),
    .pop       (pop),
    .head_data (word_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fill_level)
  );

endmodule

// File: tb/tb_rng_word_packer.sv
// Bench for rng_word_packer: a queue-based word model checked every cycle,
// directed scenarios, randomized traffic and a 2-byte/2-deep instance.
module tb_rng_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        word_ready = 1'b0;
  logic        word_valid;
  logic [31:0] word_data;
  logic [2:0]  fill_level;
  logic        overflow;

  logic        clear2 = 1'b0;
  logic        byte_valid2 = 1'b0;
  logic [7:0]  byte_data2 = 8'h00;
  logic        word_ready2 = 1'b0;
  logic        word_valid2;
  logic [15:0] word_data2;
  logic [1:0]  fill_level2;
  logic        overflow2;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  byte_q[$];
  bit          exp_ovf = 1'b0;

  always #5 clk = ~clk;

  rng_word_packer dut (
    .clk(clk), .rst(rst), .clear(clear), .byte_valid(byte_valid), .byte_data(byte_data),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .fill_level(fill_level), .overflow(overflow)
  );

  rng_word_packer #(.WORD_BYTES(2), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .byte_valid(byte_valid2), .byte_data(byte_data2),
    .word_valid(word_valid2), .word_ready(word_ready2), .word_data(word_data2),
    .fill_level(fill_level2), .overflow(overflow2)
  );

  function automatic logic [31:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : 32'h0;
  endfunction

  // Drives one cycle from a negedge and advances the word-level model at the posedge.
  task automatic drive_cycle(input bit clr, input bit bv, input logic [7:0] bd, input bit rdy);
    logic [31:0] w;
    bit popped;
    clear = clr; byte_valid = bv; byte_data = bd; word_ready = rdy;
    @(posedge clk);
    if (clr) begin
      exp_q.delete(); byte_q.delete(); exp_ovf = 1'b0;
    end else begin
      popped = (exp_q.size() != 0) && rdy;
      if (popped) void'(exp_q.pop_front());
      if (bv) begin
        byte_q.push_back(bd);
        if (byte_q.size() == 4) begin
          w = 32'h0;
          for (int i = 0; i < 4; i++) w = w | (32'(byte_q[i]) << (8 * i));
          byte_q.delete();
          if (exp_q.size() < 4) exp_q.push_back(w);
          else exp_ovf = 1'b1;
        end
      end
    end
    @(negedge clk);
    clear = 1'b0; byte_valid = 1'b0; word_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    total_cnt++;
    if (word_valid !== 1'b0 || word_data !== 32'h0 || fill_level !== 3'd0 || overflow !== 1'b0)
      $display("FAIL reset: valid=%b data=%h lvl=%0d ovf=%b, want all zero", word_valid, word_data, fill_level, overflow);
    else pass_cnt++;
    total_cnt++;
    if (word_valid2 !== 1'b0 || word_data2 !== 16'h0 || fill_level2 !== 2'd0 || overflow2 !== 1'b0)
      $display("FAIL reset_small: valid=%b data=%h lvl=%0d ovf=%b, want all zero", word_valid2, word_data2, fill_level2, overflow2);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, c < 4, (c < 4) ? bytes[c] : 8'h00, 1'b1);
      total_cnt++;
      if (word_valid !== (exp_q.size() != 0) || word_data !== exp_head() || fill_level !== 3'(exp_q.size()) || overflow !== exp_ovf)
        $display("FAIL basic c%0d: valid=%b data=%h lvl=%0d ovf=%b, want %b %h %0d %b", c, word_valid, word_data, fill_level, overflow, exp_q.size() != 0, exp_head(), exp_q.size(), exp_ovf);
      else pass_cnt++;
      if (c == 3) begin
        total_cnt++;
        if (word_valid !== 1'b1 || word_data !== 32'h44332211)
          $display("FAIL basic_word: valid=%b data=%h, want 1 44332211", word_valid, word_data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_fill_overflow();
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b0, 1'b1, 8'(c), 1'b0);
      total_cnt++;
      if (word_valid !== (exp_q.size() != 0) || word_data !== exp_head() || fill_level !== 3'(exp_q.size()) || overflow !== exp_ovf)
        $display("FAIL fill c%0d: valid=%b data=%h lvl=%0d ovf=%b, want %b %h %0d %b", c, word_valid, word_data, fill_level, overflow, exp_q.size() != 0, exp_head(), exp_q.size(), exp_ovf);
      else pass_cnt++;
    end
    total_cnt++;
    if (fill_level !== 3'd4 || overflow !== 1'b1 || word_data !== 32'h03020100)
      $display("FAIL fill_end: lvl=%0d ovf=%b data=%h, want 4 1 03020100", fill_level, overflow, word_data);
    else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if (word_data !== ((c < 4) ? {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)} : 32'h0))
        $display("FAIL drain w%0d: data=%h", c, word_data);
      else pass_cnt++;
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
      total_cnt++;
      if (word_valid !== (exp_q.size() != 0) || fill_level !== 3'(exp_q.size()) || overflow !== 1'b1)
        $display("FAIL drain c%0d: valid=%b lvl=%0d ovf=%b, want %b %0d 1", c, word_valid, fill_level, overflow, exp_q.size() != 0, exp_q.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] last_word;
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), c == 19);
      total_cnt++;
      if (word_valid !== (exp_q.size() != 0) || word_data !== exp_head() || fill_level !== 3'(exp_q.size()) || overflow !== exp_ovf)
        $display("FAIL ppfull c%0d: valid=%b data=%h lvl=%0d ovf=%b, want %b %h %0d %b", c, word_valid, word_data, fill_level, overflow, exp_q.size() != 0, exp_head(), exp_q.size(), exp_ovf);
      else pass_cnt++;
    end
    last_word = exp_q[exp_q.size() - 1];
    total_cnt++;
    if (fill_level !== 3'd4 || overflow !== 1'b0)
      $display("FAIL ppfull_state: lvl=%0d ovf=%b, want 4 0", fill_level, overflow);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        total_cnt++;
        if (word_data !== last_word) $display("FAIL ppfull_last: data=%h, want %h", word_data, last_word);
        else pass_cnt++;
      end
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    total_cnt++;
    if (word_valid !== 1'b0 || fill_level !== 3'd0)
      $display("FAIL ppfull_empty: valid=%b lvl=%0d, want 0 0", word_valid, fill_level);
    else pass_cnt++;
  endtask

  task automatic test_clear_mid();
    drive_cycle(1'b0, 1'b1, 8'h55, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h66, 1'b0);
    drive_cycle(1'b1, 1'b1, 8'h77, 1'b1);
    for (int c = 0; c < 4; c++) drive_cycle(1'b0, 1'b1, 8'hA0 + 8'(c), 1'b0);
    total_cnt++;
    if (word_valid !== 1'b1 || word_data !== 32'hA3A2A1A0 || fill_level !== 3'd1 || overflow !== 1'b0)
      $display("FAIL clear_mid: valid=%b data=%h lvl=%0d ovf=%b, want 1 a3a2a1a0 1 0", word_valid, word_data, fill_level, overflow);
    else pass_cnt++;
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (word_valid !== (exp_q.size() != 0) || fill_level !== 3'(exp_q.size()))
      $display("FAIL clear_mid_pop: valid=%b lvl=%0d, want %b %0d", word_valid, fill_level, exp_q.size() != 0, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [7:0] b [4];
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 20; c++) drive_cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (fill_level !== 3'd3 || overflow !== 1'b1 || word_data !== exp_head())
      $display("FAIL areset_pre: lvl=%0d ovf=%b data=%h, want 3 1 %h", fill_level, overflow, word_data, exp_head());
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (word_valid !== 1'b0 || word_data !== 32'h0 || fill_level !== 3'd0 || overflow !== 1'b0)
      $display("FAIL areset: valid=%b data=%h lvl=%0d ovf=%b, want all zero", word_valid, word_data, fill_level, overflow);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); byte_q.delete(); exp_ovf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      b[c] = 8'($urandom_range(0, 255));
      drive_cycle(1'b0, 1'b1, b[c], 1'b0);
    end
    total_cnt++;
    if (word_valid !== 1'b1 || word_data !== {b[3], b[2], b[1], b[0]} || fill_level !== 3'd1 || overflow !== 1'b0)
      $display("FAIL areset_after: valid=%b data=%h lvl=%0d ovf=%b, want 1 %h 1 0", word_valid, word_data, fill_level, overflow, {b[3], b[2], b[1], b[0]});
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit clr, bv, rdy;
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 63) == 0);
      bv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      drive_cycle(clr, bv, 8'($urandom_range(0, 255)), rdy);
      total_cnt++;
      if (word_valid !== (exp_q.size() != 0) || word_data !== exp_head() || fill_level !== 3'(exp_q.size()) || overflow !== exp_ovf)
        $display("FAIL random c%0d: valid=%b data=%h lvl=%0d ovf=%b, want %b %h %0d %b", c, word_valid, word_data, fill_level, overflow, exp_q.size() != 0, exp_head(), exp_q.size(), exp_ovf);
      else pass_cnt++;
    end
  endtask

  task automatic test_small_params();
    byte_valid2 = 1'b1; byte_data2 = 8'hBE;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if (word_valid2 !== 1'b0) $display("FAIL small_partial: valid=%b, want 0", word_valid2);
    else pass_cnt++;
    byte_data2 = 8'hEF;
    @(posedge clk); @(negedge clk);
    byte_valid2 = 1'b0;
    total_cnt++;
    if (word_valid2 !== 1'b1 || word_data2 !== 16'hEFBE || fill_level2 !== 2'd1)
      $display("FAIL small_word: valid=%b data=%h lvl=%0d, want 1 efbe 1", word_valid2, word_data2, fill_level2);
    else pass_cnt++;
    word_ready2 = 1'b1;
    @(posedge clk); @(negedge clk);
    word_ready2 = 1'b0;
    total_cnt++;
    if (word_valid2 !== 1'b0 || fill_level2 !== 2'd0 || overflow2 !== 1'b0)
      $display("FAIL small_pop: valid=%b lvl=%0d ovf=%b, want 0 0 0", word_valid2, fill_level2, overflow2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_push_pop_full();
    test_clear_mid();
    test_async_reset();
    test_random();
    test_small_params();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
